traffic_phase_sched: RTL and testbench
======================================

// Module: traffic_phase_sched
// PURPOSE
//  Phase scheduler for the 4-approach intersection datapath driving o_ct/o_wt.
//  Round-robins green among approaches with pending vehicle/pedestrian demand and skips idle ones.
//  Sequences GREEN->YELLOW->ALL_RED per phase and gates crosswalk WALK.
//  Sits between request inputs (sensors/buttons) and lamp drivers inside top.
// PARAMETERS
//  GREEN_T   8   green duration in ticks (>= WALK_T+1)
//  WALK_T    5   ticks of steady WALK at start of green; FLASH for the remaining green
//  YELLOW_T  3   yellow duration in ticks
//  ALLRED_T  2   all-red clearance in ticks (>=1)
//  CNT_W     4   phase timer width; must hold max(GREEN_T,YELLOW_T,ALLRED_T)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset_n    in   1   asynchronous active-low reset
//  i_start    in   1   level run enable
//  i_tick     in   1   1-cycle timebase strobe; all timers advance only when high
//  i_car_req  in   4   vehicle demand pulse/level per approach k=0..3 (N,E,S,W)
//  i_ped_req  in   4   crosswalk button per approach k
//  o_ct       out  16  lamp nibble per approach [4k+3:4k]: 0001 red, 0010 yellow, 0100 green
//  o_wt       out  8   walk per crosswalk [2k+1:2k]: 01 DONT_WALK, 10 WALK, 11 FLASH
//  o_phase    out  2   approach currently owning (or last owning) green
//  o_busy     out  1   1 when not IDLE
// BEHAVIOUR
//  Reset: state IDLE, timer 0, pend_car=pend_ped=0, o_ct=16'h1111, o_wt=8'h55, o_phase=0, o_busy=0.
//  All outputs registered; reflect state one clk after transition.
//  Latch: pend_car[k] |= i_car_req[k], pend_ped[k] |= i_ped_req[k] every clk (tick independent).
//  Clear: pend_*[k] cleared on entry to GREEN(k); request on k during GREEN(k) is absorbed (not latched);
//   during YELLOW(k)/ALL_RED it latches. Set and clear same clk on k -> clear wins.
//  FSM (timer loads on entry, decrements on i_tick, exit when timer==1 and i_tick):
//   IDLE: all red, DONT_WALK. i_start=1 -> ALL_RED (timer=ALLRED_T).
//   ALL_RED: all red. On expiry: i_start=0 -> IDLE; else search k=o_phase+1..o_phase+4 (mod 4)
//    for first pend_car|pend_ped; found -> GREEN(k), o_phase=k; none -> stay ALL_RED, re-search each tick.
//    Sole requester equal to o_phase is granted again (search wraps to itself last).
//   GREEN(k): nibble k=0100, others 0001, timer=GREEN_T. If pend_ped[k] latched at entry:
//    o_wt[k]=WALK for first WALK_T ticks, FLASH for rest; else DONT_WALK. Other crosswalks DONT_WALK.
//    Expiry -> YELLOW(k).
//   YELLOW(k): nibble k=0010, all DONT_WALK, timer=YELLOW_T; expiry -> ALL_RED.
//  i_start falling mid-phase: current phase completes (GREEN/YELLOW/ALL_RED), then IDLE.
//  i_tick high in a cycle with state entry: counts for new state only from next tick.
//  Async reset mid-operation: immediate return to reset values; pending requests lost.
//  Never two approaches non-red simultaneously; YELLOW and ALL_RED never skipped.
// CONFIGURATION
//  EMERGENCY_PREEMPT_EN defined: adds ports i_emg (in,1) and i_emg_dir (in,2).
//   i_emg rising while GREEN(j), j!=i_emg_dir -> YELLOW(j) next clk, then ALL_RED, then GREEN(i_emg_dir);
//   while i_emg=1 green timer frozen, all o_wt=DONT_WALK; i_emg low -> remaining green then normal.
//   i_emg during GREEN(i_emg_dir): hold green. During YELLOW/ALL_RED: finish them, then GREEN(i_emg_dir).
//   Preempted approach keeps no pending clear (re-requested demand persists).
//  Not defined: ports absent, no preemption logic; scheduling as above only.
// TESTING (i_tick=1 every clk unless stated, defaults)
//  1 Reset: reset_n=0 -> o_ct=16'h1111, o_wt=8'h55, o_busy=0; holds with i_start=0.
//  2 Single car: i_start=1, pulse i_car_req=4'b0100 -> after 2 ALL_RED ticks o_ct[11:8]=0100 for 8 clk,
//    0010 for 3 clk, then 16'h1111; o_phase=2; o_wt stays 8'h55.
//  3 Round-robin: i_car_req=4'b1011 held one clk -> green order 0,1,3; approach 2 skipped; no overlap.
//  4 Ped: i_ped_req[1]=1 -> GREEN(1) with o_wt[3:2]=10 for 5 clk, 11 for 3 clk, then 01.
//  5 Stop/reset: i_start=0 during GREEN(0) -> completes yellow+all-red then IDLE, o_busy=0;
//    reset_n=0 mid-GREEN -> o_ct=16'h1111 same time step.
//  6 Preempt (macro on): GREEN(0) tick 2, i_emg=1,i_emg_dir=3 -> YELLOW(0) next clk,
//    ALL_RED 2, GREEN(3) held until i_emg=0.

Source files
------------

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched
// Four-approach phase scheduler for the intersection lamp/walk drivers.
// Green is round-robined among approaches that have latched car or pedestrian
// demand. Every phase runs GREEN -> YELLOW -> ALL_RED, and the crosswalk of the
// green approach gets WALK/FLASH only when a pedestrian request was latched
// before the green started.
// Optional feature macro: EMERGENCY_PREEMPT_EN adds i_emg/i_emg_dir preemption.
// Every output is registered and decoded from the next-state values, so the
// outputs always match the state register.
module traffic_phase_sched #(
   parameter int GREEN_T  = 8,
   parameter int WALK_T   = 5,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 2,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_start,
   input  logic        i_tick,
   input  logic [3:0]  i_car_req,
   input  logic [3:0]  i_ped_req,
`ifdef EMERGENCY_PREEMPT_EN
   input  logic        i_emg,
   input  logic [1:0]  i_emg_dir,
`endif
   output logic [15:0] o_ct,
   output logic [7:0]  o_wt,
   output logic [1:0]  o_phase,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ALLRED = 2'd1,
      ST_GREEN  = 2'd2,
      ST_YELLOW = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] TMR_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] TMR_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T);
   localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T);
   localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T);
   // The timer counts down from GREEN_T, so the WALK window is timer > GREEN_T-WALK_T
   localparam logic [CNT_W-1:0] WALK_THR  = CNT_W'(GREEN_T - WALK_T);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [3:0]       pend_car_q, pend_car_d;
   logic [3:0]       pend_ped_q, pend_ped_d;
   logic [1:0]       phase_q, phase_d;
   logic             walk_en_q, walk_en_d;
   logic [15:0]      ct_q, ct_d;
   logic [7:0]       wt_q, wt_d;
   logic             busy_q, busy_d;

   logic [2:0]       grant_s;
   logic             expire_s;
   logic [3:0]       absorb_s;
   logic             walk_ok_s;

   // Round-robin search: offsets +1..+4 from the current phase, so the current
   // phase itself is considered last. Result is {found, index}.
   function automatic logic [2:0] pick_next(input logic [1:0] cur, input logic [3:0] pend);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 4; i >= 1; i--) begin
         idx = cur + i[1:0];
         if (pend[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign grant_s  = pick_next(phase_q, pend_car_q | pend_ped_q);
   assign expire_s = i_tick && (timer_q == TMR_ONE);
   // Requests for the approach that currently holds green are dropped
   assign absorb_s = (state_q == ST_GREEN) ? (4'b0001 << phase_q) : 4'b0000;

`ifdef EMERGENCY_PREEMPT_EN
   assign walk_ok_s = walk_en_d & ~i_emg;
`else
   assign walk_ok_s = walk_en_d;
`endif

   // Next-state, timer and pending-demand logic
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      phase_d    = phase_q;
      walk_en_d  = walk_en_q;
      pend_car_d = (pend_car_q | i_car_req) & ~absorb_s;
      pend_ped_d = (pend_ped_q | i_ped_req) & ~absorb_s;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d = ST_ALLRED;
               timer_d = ALLRED_LD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ALLRED: begin
            if (expire_s) begin
               if (!i_start) begin
                  state_d = ST_IDLE;
                  timer_d = TMR_ZERO;
               end
`ifdef EMERGENCY_PREEMPT_EN
               else if (i_emg) begin
                  state_d               = ST_GREEN;
                  timer_d               = GREEN_LD;
                  phase_d               = i_emg_dir;
                  walk_en_d             = 1'b0;
                  pend_car_d[i_emg_dir] = 1'b0;
                  pend_ped_d[i_emg_dir] = 1'b0;
               end
`endif
               else if (grant_s[2]) begin
                  state_d                  = ST_GREEN;
                  timer_d                  = GREEN_LD;
                  phase_d                  = grant_s[1:0];
                  walk_en_d                = pend_ped_q[grant_s[1:0]];
                  pend_car_d[grant_s[1:0]] = 1'b0;
                  pend_ped_d[grant_s[1:0]] = 1'b0;
               end else begin
                  // Nobody waiting: park at 1 so the search repeats every tick
                  timer_d = TMR_ONE;
               end
            end else if (i_tick) begin
               timer_d = timer_q - TMR_ONE;
            end else begin
               timer_d = timer_q;
            end
         end
         ST_GREEN: begin
`ifdef EMERGENCY_PREEMPT_EN
            if (i_emg && (i_emg_dir != phase_q)) begin
               state_d = ST_YELLOW;
               timer_d = YELLOW_LD;
            end else if (i_emg) begin
               timer_d = timer_q;
            end else
`endif
            if (expire_s) begin
               state_d = ST_YELLOW;
               timer_d = YELLOW_LD;
            end else if (i_tick) begin
               timer_d = timer_q - TMR_ONE;
            end else begin
               timer_d = timer_q;
            end
         end
         ST_YELLOW: begin
            if (expire_s) begin
               state_d = ST_ALLRED;
               timer_d = ALLRED_LD;
            end else if (i_tick) begin
               timer_d = timer_q - TMR_ONE;
            end else begin
               timer_d = timer_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = TMR_ZERO;
         end
      endcase
   end

   // Lamp and walk decode from next-state so the registered outputs track state_q
   always_comb begin
      ct_d   = 16'h1111;
      wt_d   = 8'h55;
      busy_d = (state_d != ST_IDLE);
      case (state_d)
         ST_GREEN: begin
            ct_d[{phase_d, 2'b00} +: 4] = 4'b0100;
            if (walk_ok_s) begin
               wt_d[{phase_d, 1'b0} +: 2] = (timer_d > WALK_THR) ? 2'b10 : 2'b11;
            end else begin
               wt_d = 8'h55;
            end
         end
         ST_YELLOW: begin
            ct_d[{phase_d, 2'b00} +: 4] = 4'b0010;
         end
         default: begin
            ct_d = 16'h1111;
            wt_d = 8'h55;
         end
      endcase
   end

   // Control state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         timer_q    <= TMR_ZERO;
         pend_car_q <= 4'b0000;
         pend_ped_q <= 4'b0000;
         phase_q    <= 2'd0;
         walk_en_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         pend_car_q <= pend_car_d;
         pend_ped_q <= pend_ped_d;
         phase_q    <= phase_d;
         walk_en_q  <= walk_en_d;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ct_q   <= 16'h1111;
         wt_q   <= 8'h55;
         busy_q <= 1'b0;
      end else begin
         ct_q   <= ct_d;
         wt_q   <= wt_d;
         busy_q <= busy_d;
      end
   end

   assign o_ct    = ct_q;
   assign o_wt    = wt_q;
   assign o_phase = phase_q;
   assign o_busy  = busy_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed testbench for traffic_phase_sched (default build).
module tb_traffic_phase_sched;

   logic        clk;
   logic        reset_n;
   logic        i_start;
   logic        i_tick;
   logic [3:0]  i_car_req;
   logic [3:0]  i_ped_req;
   logic [15:0] o_ct;
   logic [7:0]  o_wt;
   logic [1:0]  o_phase;
   logic        o_busy;
`ifdef EMERGENCY_PREEMPT_EN
   logic        i_emg;
   logic [1:0]  i_emg_dir;
`endif

   int checks;
   int errors;

   traffic_phase_sched dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_start   (i_start),
      .i_tick    (i_tick),
      .i_car_req (i_car_req),
      .i_ped_req (i_ped_req),
`ifdef EMERGENCY_PREEMPT_EN
      .i_emg     (i_emg),
      .i_emg_dir (i_emg_dir),
`endif
      .o_ct      (o_ct),
      .o_wt      (o_wt),
      .o_phase   (o_phase),
      .o_busy    (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] e_ct, input logic [7:0] e_wt,
                        input logic [1:0] e_ph, input logic e_busy);
      checks++;
      assert (o_ct === e_ct) else begin
         errors++;
         $error("FAIL %s o_ct got %h expected %h", tag, o_ct, e_ct);
      end
      checks++;
      assert (o_wt === e_wt) else begin
         errors++;
         $error("FAIL %s o_wt got %h expected %h", tag, o_wt, e_wt);
      end
      checks++;
      assert (o_phase === e_ph) else begin
         errors++;
         $error("FAIL %s o_phase got %0d expected %0d", tag, o_phase, e_ph);
      end
      checks++;
      assert (o_busy === e_busy) else begin
         errors++;
         $error("FAIL %s o_busy got %b expected %b", tag, o_busy, e_busy);
      end
   endtask

   // Entered at the negedge before the edge that grants GREEN(k); checks
   // 8 green, 3 yellow and 2 all-red cycles. stop drops i_start after green cycle 0.
   task automatic run_phase(input string tag, input logic [1:0] k, input logic walk,
                            input logic stop);
      logic [15:0] g_ct;
      logic [15:0] y_ct;
      logic [7:0]  w;
      g_ct = 16'h1111;
      g_ct[{k, 2'b00} +: 4] = 4'b0100;
      y_ct = 16'h1111;
      y_ct[{k, 2'b00} +: 4] = 4'b0010;
      for (int g = 0; g < 8; g++) begin
         @(negedge clk);
         w = 8'h55;
         if (walk) w[{k, 1'b0} +: 2] = (g < 5) ? 2'b10 : 2'b11;
         check($sformatf("%s_green%0d", tag, g), g_ct, w, k, 1'b1);
         if (stop && g == 0) i_start = 1'b0;
      end
      for (int y = 0; y < 3; y++) begin
         @(negedge clk);
         check($sformatf("%s_yellow%0d", tag, y), y_ct, 8'h55, k, 1'b1);
      end
      for (int a = 0; a < 2; a++) begin
         @(negedge clk);
         check($sformatf("%s_allred%0d", tag, a), 16'h1111, 8'h55, k, 1'b1);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset_n   = 1'b0;
      i_start   = 1'b0;
      i_tick    = 1'b1;
      i_car_req = 4'b0000;
      i_ped_req = 4'b0000;
`ifdef EMERGENCY_PREEMPT_EN
      i_emg     = 1'b0;
      i_emg_dir = 2'd0;
`endif
      // Reset values, then idle hold with i_start low
      repeat (2) @(negedge clk);
      check("reset", 16'h1111, 8'h55, 2'd0, 1'b0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_hold", 16'h1111, 8'h55, 2'd0, 1'b0);

      // Single car on approach 2
      i_start   = 1'b1;
      i_car_req = 4'b0100;
      @(negedge clk);
      i_car_req = 4'b0000;
      check("single_allred_a", 16'h1111, 8'h55, 2'd0, 1'b1);
      @(negedge clk);
      check("single_allred_b", 16'h1111, 8'h55, 2'd0, 1'b1);
      run_phase("single", 2'd2, 1'b0, 1'b0);

      // Round-robin from phase 2 over 1011: 3, 0, 1; 2 skipped
      i_car_req = 4'b1011;
      @(negedge clk);
      i_car_req = 4'b0000;
      check("rr_wait", 16'h1111, 8'h55, 2'd2, 1'b1);
      run_phase("rr_a", 2'd3, 1'b0, 1'b0);
      run_phase("rr_b", 2'd0, 1'b0, 1'b0);
      run_phase("rr_c", 2'd1, 1'b0, 1'b0);

      // Pedestrian on 1 while phase is 1: search wraps to itself, WALK then FLASH
      i_ped_req = 4'b0010;
      @(negedge clk);
      i_ped_req = 4'b0000;
      check("ped_wait", 16'h1111, 8'h55, 2'd1, 1'b1);
      run_phase("ped", 2'd1, 1'b1, 1'b0);

      // i_start dropped during GREEN(0): phase completes, then IDLE
      i_car_req = 4'b0001;
      @(negedge clk);
      i_car_req = 4'b0000;
      check("stop_wait", 16'h1111, 8'h55, 2'd1, 1'b1);
      run_phase("stop", 2'd0, 1'b0, 1'b1);
      @(negedge clk);
      check("stop_idle", 16'h1111, 8'h55, 2'd0, 1'b0);

      // Demand latched in IDLE is served after restart
      i_car_req = 4'b0100;
      @(negedge clk);
      i_car_req = 4'b0000;
      check("idle_latch", 16'h1111, 8'h55, 2'd0, 1'b0);
      i_start = 1'b1;
      @(negedge clk);
      check("restart_allred_a", 16'h1111, 8'h55, 2'd0, 1'b1);
      @(negedge clk);
      check("restart_allred_b", 16'h1111, 8'h55, 2'd0, 1'b1);
      @(negedge clk);
      check("restart_green", 16'h1411, 8'h55, 2'd2, 1'b1);

      // Tick held low: green must not expire
      i_tick    = 1'b0;
      i_ped_req = 4'b1000;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         i_ped_req = 4'b0000;
         check($sformatf("tick_hold%0d", c), 16'h1411, 8'h55, 2'd2, 1'b1);
      end

      // Asynchronous reset mid-green
      #2 reset_n = 1'b0;
      #1 check("async_reset", 16'h1111, 8'h55, 2'd0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      i_tick  = 1'b1;
      i_start = 1'b1;
      // Pending ped demand on 3 was lost: stays all-red
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("post_reset%0d", c), 16'h1111, 8'h55, 2'd0, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
